// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory path: bus widths, responder
// state encoding and the control-strobe bundle driven by the sequencer.
package proc_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 13;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    typedef struct packed {
        logic wMAR;
        logic rMAR;
        logic rMem;
        logic wMem;
        logic wMDRmem;
        logic wMDRbus;
        logic rMDR;
    } memCtrl_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word memory with registered read data.
// No reset, so the array maps onto block RAM.
module mem_array #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8192,
    parameter int AW     = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: owns MAR/MDR and the word memory, executes the
// sequencer's memory strobes with a fixed latency and ack/busy handshake.
module mem_bus_responder #(
    parameter int DATA_W    = proc_pkg::DATA_W,
    parameter int ADDR_W    = proc_pkg::ADDR_W,
    parameter int DEPTH     = 8192,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] busIn,
    input  logic              wMAR,
    input  logic              rMAR,
    input  logic              rMem,
    input  logic              wMem,
    input  logic              wMDRmem,
    input  logic              wMDRbus,
    input  logic              rMDR,
    output logic [DATA_W-1:0] aBusOut,
    output logic [DATA_W-1:0] bBusOut,
    output logic [ADDR_W-1:0] marOut,
    output logic [DATA_W-1:0] mdrOut,
    output logic              memAck,
    output logic              busy,
    output logic              protErr
);

    import proc_pkg::memCtrl_t;
    import proc_pkg::IDLE;
    import proc_pkg::RD;
    import proc_pkg::WR;
    import proc_pkg::HOLD;

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      RD_INIT = 4'(READ_LAT - 1);
    localparam logic [3:0]      WR_INIT = 4'(WRITE_LAT - 1);

    memCtrl_t ctrl;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] wAddr;
    logic [ADDR_W-1:0] marNext;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdBuf;
    logic [DATA_W-1:0] wData;
    logic [DATA_W-1:0] ramRdata;
    logic              rdValid;
    logic              marLoadOk;
    logic              marOor;
    logic              wAddrOor;
    logic              rdDone;
    logic              wrDone;
    logic              ramWe;
    logic              errNow;

    assign ctrl = '{wMAR: wMAR, rMAR: rMAR, rMem: rMem, wMem: wMem,
                    wMDRmem: wMDRmem, wMDRbus: wMDRbus, rMDR: rMDR};

    assign marLoadOk = (state == IDLE) || (state == HOLD);
    assign marNext   = (ctrl.wMAR && marLoadOk) ? busIn[ADDR_W-1:0] : mar;
    assign marOor    = ({1'b0, mar} >= DEPTH_L);
    assign wAddrOor  = ({1'b0, wAddr} >= DEPTH_L);
    assign rdDone    = (state == RD) && (cnt == 4'd0);
    assign wrDone    = (state == WR) && (cnt == 4'd0);
    assign ramWe     = wrDone && !wAddrOor;

    // The RAM output is registered, so it is addressed with the MAR value that
    // will hold after this edge; rdata is then current for every cycle of RD.
    assign ramAddr = (state == WR) ? wAddr : marNext;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_memArray (
        .clk   (clk),
        .we    (ramWe),
        .addr  (ramAddr[AW-1:0]),
        .wdata (wData),
        .rdata (ramRdata)
    );

    always_comb begin
        errNow = 1'b0;
        if (ctrl.wMAR && !marLoadOk)                          errNow = 1'b1;
        if (ctrl.wMDRbus && ctrl.wMDRmem)                     errNow = 1'b1;
        if (ctrl.wMDRmem && !ctrl.wMDRbus && !rdValid)        errNow = 1'b1;
        if ((state == WR) && (ctrl.wMDRbus || ctrl.wMDRmem))  errNow = 1'b1;
        if ((state == IDLE) && ctrl.rMem && ctrl.wMem)        errNow = 1'b1;
        if ((rdDone && marOor) || (wrDone && wAddrOor))       errNow = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protErr <= 1'b0;
        end else if (errNow) begin
            protErr <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            mar <= marNext;
            if (state != WR) begin
                if (ctrl.wMDRbus && !ctrl.wMDRmem) begin
                    mdr <= busIn;
                end else if (ctrl.wMDRmem && !ctrl.wMDRbus && rdValid) begin
                    mdr <= rdBuf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdBuf   <= '0;
            rdValid <= 1'b0;
            wAddr   <= '0;
            wData   <= '0;
            memAck  <= 1'b0;
        end else begin
            memAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.rMem && !ctrl.wMem) begin
                        state   <= RD;
                        cnt     <= RD_INIT;
                        rdValid <= 1'b0;
                    end else if (ctrl.wMem && !ctrl.rMem) begin
                        state <= WR;
                        cnt   <= WR_INIT;
                        wAddr <= mar;
                        wData <= mdr;
                    end
                end
                RD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdBuf   <= marOor ? '0 : ramRdata;
                        rdValid <= 1'b1;
                        memAck  <= 1'b1;
                        state   <= HOLD;
                    end
                end
                WR: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        memAck <= 1'b1;
                        state  <= HOLD;
                    end
                end
                default: begin
                    // One operation per strobe assertion: wait for release.
                    if (!ctrl.rMem && !ctrl.wMem) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (state == RD) || (state == WR);
    assign marOut  = mar;
    assign mdrOut  = mdr;
    assign aBusOut = ctrl.rMAR ? DATA_W'(mar) : '0;
    assign bBusOut = ctrl.rMDR ? mdr : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against a word-level memory model.
module tb_mem_bus_responder;

    localparam int DATA_W    = 18;
    localparam int ADDR_W    = 13;
    localparam int DEPTH     = 16;
    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] busIn;
    logic              wMAR, rMAR, rMem, wMem, wMDRmem, wMDRbus, rMDR;
    logic [DATA_W-1:0] aBusOut, bBusOut, mdrOut;
    logic [ADDR_W-1:0] marOut;
    logic              memAck, busy, protErr;

    mem_bus_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk), .reset(reset), .busIn(busIn),
        .wMAR(wMAR), .rMAR(rMAR), .rMem(rMem), .wMem(wMem),
        .wMDRmem(wMDRmem), .wMDRbus(wMDRbus), .rMDR(rMDR),
        .aBusOut(aBusOut), .bBusOut(bBusOut), .marOut(marOut), .mdrOut(mdrOut),
        .memAck(memAck), .busy(busy), .protErr(protErr)
    );

    always #5 clk = ~clk;

    int checkCnt = 0;
    int errCnt   = 0;

    logic [DATA_W-1:0] refMem [DEPTH];
    logic [ADDR_W-1:0] refMar;
    logic [DATA_W-1:0] refMdr;
    logic [DATA_W-1:0] refRdBuf;
    logic              refRdValid;
    logic              refProtErr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        refMar     = '0;
        refMdr     = '0;
        refRdBuf   = '0;
        refRdValid = 1'b0;
        refProtErr = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #1;
        checkVal("rst_mar", marOut, 0);
        checkVal("rst_mdr", mdrOut, 0);
        checkVal("rst_ack", memAck, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_prot", protErr, 0);
        step();
        reset = 1'b0;
        modelReset();
    endtask

    task automatic loadMar(input logic [ADDR_W-1:0] a);
        busIn = DATA_W'(a);
        wMAR  = 1'b1;
        step();
        wMAR   = 1'b0;
        refMar = a;
    endtask

    task automatic loadMdr(input logic [DATA_W-1:0] d);
        busIn   = d;
        wMDRbus = 1'b1;
        step();
        wMDRbus = 1'b0;
        refMdr  = d;
    endtask

    // Issue one read or write, holding the strobe holdLen cycles past accept.
    // poke injects an illegal MDR/MAR load while the operation is in flight.
    task automatic runOp(input bit isRead, input int holdLen, input bit poke);
        int lat;
        int acks;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        lat  = isRead ? READ_LAT : WRITE_LAT;
        acks = 0;
        a    = refMar;
        d    = refMdr;
        if (isRead) begin
            rMem = 1'b1;
            refRdValid = 1'b0;
        end else begin
            wMem = 1'b1;
        end
        step();
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) step();
            checkVal(isRead ? "rd_ack" : "wr_ack", memAck, 32'(j == lat));
            checkVal(isRead ? "rd_busy" : "wr_busy", busy, 32'(j < lat));
            if (memAck === 1'b1) acks++;
            if (j == 1) begin
                wMDRmem = 1'b0;
                wMAR    = 1'b0;
            end
            if (j == 0 && poke) begin
                if (isRead) begin
                    wMDRmem = 1'b1;
                end else begin
                    busIn = DATA_W'(~a);
                    wMAR  = 1'b1;
                end
                refProtErr = 1'b1;
            end
            if (j == holdLen) begin
                rMem = 1'b0;
                wMem = 1'b0;
            end
        end
        if (isRead) begin
            refRdBuf   = (int'(a) < DEPTH) ? refMem[a[3:0]] : '0;
            refRdValid = 1'b1;
        end else if (int'(a) < DEPTH) begin
            refMem[a[3:0]] = d;
        end
        if (int'(a) >= DEPTH) refProtErr = 1'b1;
        checkVal("ack_count", acks, 1);
        checkVal("op_prot", protErr, refProtErr);
        checkVal("op_mar", marOut, refMar);
        checkVal("op_mdr", mdrOut, refMdr);
    endtask

    task automatic fetchMdr();
        wMDRmem = 1'b1;
        step();
        wMDRmem = 1'b0;
        if (refRdValid) refMdr = refRdBuf;
        else refProtErr = 1'b1;
        rMDR = 1'b1;
        #1;
        checkVal("bbus_mdr", bBusOut, refMdr);
        rMDR = 1'b0;
        #1;
        checkVal("bbus_idle", bBusOut, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] prev7;
        logic [DATA_W-1:0] val4;
        logic [ADDR_W-1:0] ra;
        bit                isRd;

        reset = 1'b1;
        busIn = '0;
        {wMAR, rMAR, rMem, wMem, wMDRmem, wMDRbus, rMDR} = '0;
        modelReset();
        step();
        applyReset();

        // Write then read back address 5.
        loadMar(13'd5);
        loadMdr(18'h2ABCD);
        runOp(1'b0, 2, 1'b0);
        loadMar(13'd5);
        runOp(1'b1, 3, 1'b0);
        fetchMdr();
        checkVal("readback", mdrOut, 18'h2ABCD);
        checkVal("prot_clean", protErr, 0);

        // wMDRmem while a read is in flight.
        runOp(1'b1, 2, 1'b1);
        checkVal("poke_rd_mdr", mdrOut, 18'h2ABCD);

        // Simultaneous read and write request in IDLE.
        applyReset();
        rMem = 1'b1;
        wMem = 1'b1;
        step();
        checkVal("both_busy", busy, 0);
        checkVal("both_ack", memAck, 0);
        checkVal("both_prot", protErr, 1);
        step();
        checkVal("both_ack2", memAck, 0);
        rMem = 1'b0;
        wMem = 1'b0;
        refProtErr = 1'b1;

        // wMAR during a write.
        applyReset();
        loadMar(13'd6);
        loadMdr(18'h01234);
        runOp(1'b0, 1, 1'b1);
        checkVal("poke_wr_mar", marOut, 6);

        // Reset mid-write must abort the commit.
        applyReset();
        prev7 = 18'h12345;
        loadMar(13'd7);
        loadMdr(prev7);
        runOp(1'b0, 1, 1'b0);
        loadMar(13'd7);
        loadMdr(18'h3FFFF);
        rMAR = 1'b1;
        rMDR = 1'b1;
        wMem = 1'b1;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checkVal("abort_mar", marOut, 0);
        checkVal("abort_mdr", mdrOut, 0);
        checkVal("abort_abus", aBusOut, 0);
        checkVal("abort_bbus", bBusOut, 0);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_ack", memAck, 0);
        {wMem, rMAR, rMDR} = '0;
        step();
        step();
        step();
        reset = 1'b0;
        modelReset();
        loadMar(13'd7);
        runOp(1'b1, 1, 1'b0);
        fetchMdr();
        checkVal("abort_mem7", mdrOut, prev7);

        // Out-of-range accesses alias onto address 4 if not guarded.
        val4 = 18'h0A5A5;
        loadMar(13'd4);
        loadMdr(val4);
        runOp(1'b0, 2, 1'b0);
        checkVal("oor_pre_prot", protErr, 0);
        loadMar(13'd20);
        loadMdr(18'h15555);
        runOp(1'b0, 2, 1'b0);
        runOp(1'b1, 2, 1'b0);
        fetchMdr();
        checkVal("oor_rd_zero", mdrOut, 0);
        rMAR = 1'b1;
        #1;
        checkVal("oor_abus", aBusOut, 20);
        rMAR = 1'b0;
        loadMar(13'd4);
        runOp(1'b1, 1, 1'b0);
        fetchMdr();
        checkVal("oor_mem4", mdrOut, val4);

        // Randomized traffic over a fully initialised array.
        applyReset();
        for (int i = 0; i < DEPTH; i++) begin
            loadMar(ADDR_W'(i));
            loadMdr(DATA_W'($urandom));
            runOp(1'b0, $urandom_range(1, 6), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            ra   = ADDR_W'($urandom_range(0, 23));
            isRd = 1'($urandom_range(0, 1));
            loadMar(ra);
            if (!isRd) loadMdr(DATA_W'($urandom));
            runOp(isRd, $urandom_range(1, 6), ($urandom_range(0, 7) == 0));
            if (isRd) fetchMdr();
            if ($urandom_range(0, 3) == 0) begin
                rMAR = 1'b1;
                #1;
                checkVal("rnd_abus", aBusOut, 32'(refMar));
                rMAR = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the processor control strobes. It owns the MAR, the MDR and a single-port word memory.
- It executes the rMAR/wMAR/rMem/wMem/rMDR/wMDRmem/wMDRbus commands issued by the control sequencer. It returns read data to the MDR and drives MAR/MDR onto the internal buses.
- It sits between the control block, the ALU output bus and the memory. It adds a registered read/write latency and an acknowledge/busy handshake.

Parameters:
- DATA_W, 18, word width; matches the instruction/bus width.
- ADDR_W, 13, address width; MAR width, taken from bus bits [ADDR_W-1:0].
- DEPTH, 8192, memory words; must be ≤ 2^ADDR_W.
- READ_LAT, 1, cycles from read accept to data capture; range 1..15.
- WRITE_LAT, 1, cycles from write accept to array update; range 1..15.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state except memory contents.
- busIn  in  DATA_W  ALU output bus; source for wMAR and wMDRbus.
- wMAR  in  1  load MAR from busIn[ADDR_W-1:0].
- rMAR  in  1  drive MAR, zero-extended, onto aBusOut.
- rMem  in  1  memory read request (level).
- wMem  in  1  memory write request (level); writes MDR to mem[MAR].
- wMDRmem  in  1  load MDR from the read buffer.
- wMDRbus  in  1  load MDR from busIn.
- rMDR  in  1  drive MDR onto bBusOut.
- aBusOut  out  DATA_W  MAR when rMAR, else 0 (combinational).
- bBusOut  out  DATA_W  MDR when rMDR, else 0 (combinational).
- marOut  out  ADDR_W  MAR register (debug/observe).
- mdrOut  out  DATA_W  MDR register.
- memAck  out  1  one-cycle pulse when a read/write completes.
- busy  out  1  high in states RD, WR.
- protErr  out  1  sticky protocol-violation flag; cleared only by reset.

Behaviour:
- Reset (async, immediate): MAR=0, MDR=0, rdBuf=0, rdValid=0, state=IDLE, cnt=0, memAck=0, busy=0, protErr=0. Memory is untouched. A reset mid-RD or mid-WR aborts the operation; a pending write is never committed.
- Register loads at posedge:
  - wMAR: MAR<=busIn[ADDR_W-1:0], only in IDLE or HOLD. In RD/WR, MAR is held and protErr<=1.
  - wMDRbus and wMDRmem both high: MDR unchanged, protErr<=1.
  - wMDRbus alone: MDR<=busIn.
  - wMDRmem alone: MDR<=rdBuf if rdValid. If rdValid=0: MDR unchanged, protErr<=1.
  - MDR loads are blocked during WR: MDR unchanged, protErr<=1.
- FSM states: IDLE, RD, WR, HOLD.
  - IDLE, rMem=1 and wMem=0 → RD; cnt<=READ_LAT-1; rdValid<=0.
  - IDLE, wMem=1 and rMem=0 → WR; cnt<=WRITE_LAT-1; the address/data used are MAR/MDR as sampled at that edge (latched into internal wAddr/wData).
  - IDLE, both high → stay IDLE; protErr<=1.
  - RD: cnt>0 → cnt-1. cnt==0 → rdBuf<=mem[MAR]; rdValid<=1; memAck<=1; → HOLD.
  - WR: cnt>0 → cnt-1. cnt==0 → mem[wAddr]<=wData; memAck<=1; → HOLD.
  - HOLD: memAck<=0. rMem=0 and wMem=0 → IDLE; else stay. The control block holds strobes for multiple cycles; only one operation is performed per strobe assertion.
- Latency: a read accepted at edge N gives rdBuf valid and memAck high after edge N+READ_LAT. A write is the same with WRITE_LAT.
- rdValid stays 1 until the next read is accepted or reset. It is unaffected by writes, even to the same address; a stale buffer is allowed.
- Addresses with MAR ≥ DEPTH: read returns 0, write is dropped, protErr<=1. memAck is still pulsed.
- Memory read is synchronous (registered); no read-during-write hazard exists because the FSM is single-issue.

Decomposition:
- Shared package proc_pkg:
  - DATA_W and ADDR_W constants.
  - The FSM state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, HOLD=2'd3).
  - A struct/bundle typedef for the control-strobe group, so the control block and the responder share one definition.
- One sub-module, mem_array: single-port synchronous RAM (DEPTH×DATA_W). Ports: clk, we, addr, wdata, rdata. No reset. This lets it infer block RAM.

Test Plan:
- Reset release, then busIn=18'h00005 with wMAR; busIn=18'h2ABCD with wMDRbus; wMem held 2 cycles → memAck one pulse after WRITE_LAT edges; mem[5]==18'h2ABCD; busy low afterwards.
- Read-back: MAR=5; rMem held 3 cycles; then wMDRmem; then rMDR → bBusOut==18'h2ABCD; exactly one memAck pulse; protErr=0.
- READ_LAT=4: rMem at edge N → busy high for edges N..N+3; memAck after edge N+4; wMDRmem issued while busy → protErr=1, MDR unchanged.
- rMem and wMem asserted together in IDLE → no state change, memAck stays 0, protErr=1; a wMAR attempted during WR also sets protErr.
- Async reset asserted mid-WR (MAR=7, MDR=18'h3FFFF, WRITE_LAT=3, after 1 cycle) → all outputs zero immediately; mem[7] keeps its prior value.
- Out-of-range access (DEPTH=16, MAR=20): read → rdBuf=0 and memAck pulses; write → no array change; protErr=1; rMAR → aBusOut==18'd20.
